pipeline_stall_controller: RTL

Pipeline control block that consumes `hazard_detected` from `hazard_detection_unit` and acts on it, together with branch-flush and data-memory wait requests. It owns the D/X instruction register: it supplies the `execute_instruction` that the hazard unit compares and the PC/F-D write enables. It inserts NOP bubbles, freezes the pipe on memory wait, flushes on taken branches, and keeps saturating event counters for performance debug.

---
 rtl/pipeline_stall_controller_pkg.sv | 25 ++
 rtl/pipeline_stall_controller_if.sv | 46 ++++
 rtl/pipeline_stall_controller_counter.sv | 30 +++
 rtl/pipeline_stall_controller.sv | 113 +++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline definitions for the stall controller and its bench.
// Holds opcode constants, the NOP encoding, instruction field bit
// positions and the two-state enum of the memory-wait state machine.
package pipeline_pkg;

    localparam logic [4:0]  OPCODE_LOAD     = 5'b01000;
    localparam logic [4:0]  OPCODE_STORE    = 5'b00111;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

    // Instruction field bit ranges: opcode [31:27], rd [26:22], rs [21:17], rt [16:12]
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RD_MSB     = 26;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 17;
    localparam int RT_MSB     = 16;
    localparam int RT_LSB     = 12;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } stall_state_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Bundle of the stall controller's pipeline-facing signals.
//   master : the pipeline/environment side (drives hazard, branch, memory
//            handshake, clear and the F/D register contents)
//   slave  : the stall controller (drives enables, flush, D/X register,
//            wait/error flags and the event counters)
interface pipeline_stall_controller_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   hazard_detected;
    logic                   branch_taken;
    logic                   dmem_request;
    logic                   dmem_ready;
    logic                   counter_clear;
    logic [31:0]            decode_instruction;
    logic [31:0]            decode_pc;
    logic                   pc_write_enable;
    logic                   fd_write_enable;
    logic                   fd_flush;
    logic [31:0]            execute_instruction;
    logic [31:0]            execute_pc;
    logic                   execute_valid;
    logic                   mem_wait;
    logic                   protocol_error;
    logic [COUNT_WIDTH-1:0] load_stall_count;
    logic [COUNT_WIDTH-1:0] mem_wait_count;
    logic [COUNT_WIDTH-1:0] flush_count;

    modport master (
        output hazard_detected, branch_taken, dmem_request, dmem_ready,
               counter_clear, decode_instruction, decode_pc,
        input  pc_write_enable, fd_write_enable, fd_flush,
               execute_instruction, execute_pc, execute_valid,
               mem_wait, protocol_error,
               load_stall_count, mem_wait_count, flush_count
    );

    modport slave (
        input  hazard_detected, branch_taken, dmem_request, dmem_ready,
               counter_clear, decode_instruction, decode_pc,
        output pc_write_enable, fd_write_enable, fd_flush,
               execute_instruction, execute_pc, execute_valid,
               mem_wait, protocol_error,
               load_stall_count, mem_wait_count, flush_count
    );

endinterface

// File: rtl/pipeline_stall_controller_counter.sv
// Saturating event counter.
//   clock/reset_n : rising-edge clock, asynchronous active-low reset
//   clear         : synchronous clear, wins over increment
//   increment     : add one this edge unless already at all-ones
//   count         : current value
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b1}}) ? value : value + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (increment) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: owns the D/X instruction register and decides
// each cycle between mem-freeze, branch flush, load bubble and advance.
//   clock/reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)   : hazard/branch/memory handshake in; PC and F/D enables,
//                   F/D flush, D/X IR/PC/valid, wait/error flags and
//                   saturating event counters out
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    pipeline_stall_controller_if.slave  bus
);

    stall_state_t state, state_next;
    logic         freeze, flush, bubble;
    logic         error_set;
    logic         protocol_error_q;
    logic [31:0]  dx_instr_p1;
    logic [31:0]  dx_pc_p1;
    logic         vld_p1;

    // Action decode, highest priority first: freeze > flush > bubble > advance.
    // A hazard alongside a taken branch is ignored since decode is discarded.
    always_comb begin
        freeze     = bus.dmem_request && !bus.dmem_ready;
        flush      = bus.branch_taken && !freeze;
        bubble     = bus.hazard_detected && !bus.branch_taken && !freeze;
        state_next = state;
        error_set  = 1'b0;
        case (state)
            RUN: begin
                if (freeze) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_next = RUN;
                end else if (!bus.dmem_request) begin
                    // Request withdrawn before completion: recover, but flag it.
                    state_next = RUN;
                    error_set  = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign bus.pc_write_enable = !freeze && !bubble;
    assign bus.fd_write_enable = !freeze && !bubble;
    assign bus.fd_flush        = flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= RUN;
            protocol_error_q <= 1'b0;
        end else begin
            state            <= state_next;
            protocol_error_q <= protocol_error_q || error_set;
        end
    end

    // D/X stage boundary: holds on freeze, NOP on flush/bubble, else loads F/D.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dx_instr_p1 <= '0;
            dx_pc_p1    <= '0;
            vld_p1      <= 1'b0;
        end else if (!freeze) begin
            if (flush || bubble) begin
                dx_instr_p1 <= NOP_INSTRUCTION;
                dx_pc_p1    <= '0;
                vld_p1      <= 1'b0;
            end else begin
                dx_instr_p1 <= bus.decode_instruction;
                dx_pc_p1    <= bus.decode_pc;
                vld_p1      <= 1'b1;
            end
        end
    end

    assign bus.execute_instruction = dx_instr_p1;
    assign bus.execute_pc          = dx_pc_p1;
    assign bus.execute_valid       = vld_p1;
    assign bus.mem_wait            = (state == MEM_WAIT);
    assign bus.protocol_error      = protocol_error_q;

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_load_stall_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (bus.counter_clear),
        .increment (bubble),
        .count     (bus.load_stall_count)
    );

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_mem_wait_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (bus.counter_clear),
        .increment (freeze),
        .count     (bus.mem_wait_count)
    );

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_flush_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (bus.counter_clear),
        .increment (flush),
        .count     (bus.flush_count)
    );

endmodule
